logic_gate_unit: RTL and testbench

Parametrised, registered successor to the two-input gate set: a WIDTH-bit bitwise logic unit with an opcode-selected function (AND, OR, XOR, NAND, NOR, XNOR, NOT, PASS), a one-deep valid/ready output register, and an optional on-chip exhaustive sweep engine. The sweep engine drives every {a,b} combination through the selected function and folds the results into a signature. It sits between a stimulus source and any consumer that needs registered logic results, and serves as a self-checking gate block for board bring-up.

---
 rtl/logic_gate_unit.sv | 130 +++++++++++++
 tb/tb_logic_gate_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/logic_gate_unit.sv
// Registered WIDTH-bit bitwise logic unit with a one-deep valid/ready output stage.
// Optional exhaustive sweep engine built when LOGIC_GATE_UNIT_SWEEP_EN is defined.
module logic_gate_unit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   input  logic             sweep_start,
   output logic             sweep_busy,
   output logic             sweep_done,
   output logic [WIDTH-1:0] sweep_sig
);

   function automatic logic [WIDTH-1:0] gate_fn(input logic [2:0]       f,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] z);
      logic [WIDTH-1:0] r;
      case (f)
         3'd0:    r = x & z;
         3'd1:    r = x | z;
         3'd2:    r = x ^ z;
         3'd3:    r = ~(x & z);
         3'd4:    r = ~(x | z);
         3'd5:    r = ~(x ^ z);
         3'd6:    r = ~x;
         default: r = x;
      endcase
      return r;
   endfunction

   logic idle;
   logic accept;

   assign in_ready = idle && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Output register: a new result may replace the one being consumed in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         y         <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         y         <= gate_fn(op, a, b);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef LOGIC_GATE_UNIT_SWEEP_EN

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [2*WIDTH-1:0] cnt;
   logic [2:0]         op_lat;
   logic [WIDTH-1:0]   sig;
   logic               sweep_go;

   function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = x[(i + WIDTH - 1) % WIDTH];
      end
      return r;
   endfunction

   assign sweep_go = sweep_start && !out_valid && !in_valid;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (sweep_go) state_next = SWEEP;
         SWEEP:   if (&cnt) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Counter supplies {a,b} with a in the upper half; signature folds each result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         op_lat <= '0;
         sig    <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && state_next == SWEEP) begin
            op_lat <= op;
            cnt    <= '0;
            sig    <= '0;
         end else if (state == SWEEP) begin
            cnt <= cnt + 1'b1;
            sig <= rotl1(sig) ^ gate_fn(op_lat, cnt[2*WIDTH-1:WIDTH], cnt[WIDTH-1:0]);
         end
      end
   end

   assign idle       = (state == IDLE);
   assign sweep_busy = (state == SWEEP);
   assign sweep_done = (state == DONE);
   assign sweep_sig  = sig;

`else

   logic unused_sweep_start;

   assign unused_sweep_start = sweep_start;
   assign idle       = 1'b1;
   assign sweep_busy = 1'b0;
   assign sweep_done = 1'b0;
   assign sweep_sig  = '0;

`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed bench for logic_gate_unit: WIDTH=4 data path and WIDTH=1 instance,
// with sweep checks selected by LOGIC_GATE_UNIT_SWEEP_EN.
module tb_logic_gate_unit;

   logic       clk;
   logic       rst;
   int         n_vec;
   int         n_bad;

   // WIDTH=4 instance
   logic       in_valid, in_ready, out_valid, out_ready;
   logic [3:0] a, b, y, sweep_sig;
   logic [2:0] op;
   logic       sweep_start, sweep_busy, sweep_done;

   // WIDTH=1 instance
   logic       in_valid_1, in_ready_1, out_valid_1, out_ready_1;
   logic [0:0] a_1, b_1, y_1, sweep_sig_1;
   logic [2:0] op_1;
   logic       sweep_start_1, sweep_busy_1, sweep_done_1;

   logic_gate_unit #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op),
      .out_valid(out_valid), .out_ready(out_ready), .y(y),
      .sweep_start(sweep_start), .sweep_busy(sweep_busy),
      .sweep_done(sweep_done), .sweep_sig(sweep_sig)
   );

   logic_gate_unit #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_1), .in_ready(in_ready_1),
      .a(a_1), .b(b_1), .op(op_1),
      .out_valid(out_valid_1), .out_ready(out_ready_1), .y(y_1),
      .sweep_start(sweep_start_1), .sweep_busy(sweep_busy_1),
      .sweep_done(sweep_done_1), .sweep_sig(sweep_sig_1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic xfer4(input logic [2:0] f, input logic [3:0] exp);
      op = f;
      in_valid = 1'b1;
      #1;
      check("w4 in_ready before xfer", in_ready, 1'b1);
      step();
      check("w4 y", y, exp);
      check("w4 out_valid", out_valid, 1'b1);
   endtask

`ifdef LOGIC_GATE_UNIT_SWEEP_EN
   task automatic sweep1(input logic [2:0] f, input logic exp_sig);
      int busy_cnt;
      op_1 = f;
      sweep_start_1 = 1'b1;
      step();
      sweep_start_1 = 1'b0;
      busy_cnt = 0;
      while (sweep_busy_1 && busy_cnt < 20) begin
         busy_cnt++;
         step();
      end
      check("w1 sweep busy cycles", busy_cnt, 4);
      check("w1 sweep done pulse", sweep_done_1, 1'b1);
      check("w1 sweep sig", sweep_sig_1, exp_sig);
      step();
      check("w1 sweep done cleared", sweep_done_1, 1'b0);
      check("w1 sweep sig held", sweep_sig_1, exp_sig);
   endtask
`endif

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b1; a = 4'h0; b = 4'h0; op = 3'd0; sweep_start = 1'b0;
      in_valid_1 = 1'b0; out_ready_1 = 1'b1; a_1 = 1'b0; b_1 = 1'b0; op_1 = 3'd0;
      sweep_start_1 = 1'b0;
      step();
      step();
      check("rst in_ready", in_ready, 1'b1);
      check("rst out_valid", out_valid, 1'b0);
      check("rst y", y, 4'h0);
      check("rst sweep_busy", sweep_busy, 1'b0);
      check("rst sweep_done", sweep_done, 1'b0);
      check("rst sweep_sig", sweep_sig, 4'h0);
      rst = 1'b0;

      // Back-to-back transfers, out_ready held high.
      a = 4'hC; b = 4'hA;
      xfer4(3'd2, 4'h6);
      xfer4(3'd3, 4'h7);
      xfer4(3'd4, 4'h1);
      xfer4(3'd6, 4'h3);
      xfer4(3'd0, 4'h8);
      xfer4(3'd1, 4'hE);
      xfer4(3'd5, 4'h9);
      xfer4(3'd7, 4'hC);
      in_valid = 1'b0;
      step();
      check("w4 consume out_valid", out_valid, 1'b0);
      check("w4 consume y held", y, 4'hC);

      // Backpressure.
      out_ready = 1'b0;
      a = 4'hF; b = 4'h3; op = 3'd0; in_valid = 1'b1;
      step();
      check("bp first y", y, 4'h3);
      check("bp first out_valid", out_valid, 1'b1);
      a = 4'h0;
      for (int i = 0; i < 10; i++) begin
         check("bp in_ready", in_ready, 1'b0);
         step();
         check("bp y stable", y, 4'h3);
         check("bp out_valid stable", out_valid, 1'b1);
      end
      a = 4'h5; b = 4'h3; op = 3'd1; out_ready = 1'b1;
      #1;
      check("bp release in_ready", in_ready, 1'b1);
      step();
      check("bp release y", y, 4'h7);
      check("bp release out_valid", out_valid, 1'b1);
      in_valid = 1'b0;
      step();
      check("bp drain out_valid", out_valid, 1'b0);

      // sweep_start while a result is pending is ignored.
      a = 4'h9; b = 4'h5; op = 3'd2; in_valid = 1'b1;
      step();
      in_valid = 1'b0; out_ready = 1'b0; sweep_start = 1'b1;
      step();
      check("start during out_valid busy", sweep_busy, 1'b0);
      check("start during out_valid y", y, 4'hC);
      sweep_start = 1'b0; out_ready = 1'b1;
      step();
      check("start during out_valid drained", out_valid, 1'b0);

      // WIDTH=1 data path.
      a_1 = 1'b1; b_1 = 1'b0; op_1 = 3'd1; in_valid_1 = 1'b1;
      step();
      check("w1 y or", y_1, 1'b1);
      op_1 = 3'd0;
      step();
      check("w1 y and", y_1, 1'b0);
      check("w1 out_valid", out_valid_1, 1'b1);
      in_valid_1 = 1'b0;
      step();
      check("w1 drained", out_valid_1, 1'b0);

`ifdef LOGIC_GATE_UNIT_SWEEP_EN
      sweep1(3'd0, 1'b1);
      sweep1(3'd2, 1'b0);
      sweep1(3'd3, 1'b1);

      // Reset in the middle of a WIDTH=4 sweep.
      op = 3'd0; sweep_start = 1'b1;
      step();
      sweep_start = 1'b0;
      check("w4 sweep busy", sweep_busy, 1'b1);
      check("w4 sweep in_ready", in_ready, 1'b0);
      for (int i = 1; i < 100; i++) step();
      check("w4 sweep busy at 100", sweep_busy, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid-sweep rst busy", sweep_busy, 1'b0);
      check("mid-sweep rst done", sweep_done, 1'b0);
      check("mid-sweep rst sig", sweep_sig, 4'h0);
      check("mid-sweep rst in_ready", in_ready, 1'b1);
      check("mid-sweep rst out_valid", out_valid, 1'b0);
`else
      // Sweep engine absent: start pulse has no effect.
      sweep_start = 1'b1; sweep_start_1 = 1'b1;
      step();
      sweep_start = 1'b0; sweep_start_1 = 1'b0;
      check("nosweep busy", sweep_busy, 1'b0);
      check("nosweep done", sweep_done, 1'b0);
      check("nosweep sig", sweep_sig, 4'h0);
      check("nosweep in_ready", in_ready, 1'b1);
      check("nosweep w1 busy", sweep_busy_1, 1'b0);
      check("nosweep w1 sig", sweep_sig_1, 1'b0);
      step();
      check("nosweep done later", sweep_done, 1'b0);
      a = 4'h6; b = 4'h3;
      xfer4(3'd4, 4'h8);
      in_valid = 1'b0;
      step();
      check("nosweep drained", out_valid, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
